sipo_frame_deserializer: RTL and testbench
==========================================

# sipo_frame_deserializer

Serial-in, parallel-out front end that feeds the 4-bit parallel storage register. It samples a framed serial bit stream, qualified by a per-bit strobe: start bit, DATA_W data bits LSB first, optional even parity, stop bit. It assembles each frame into a parallel word, holds it in a one-deep output buffer, and presents it with a valid/ready handshake. It flags parity errors, framing errors and overruns, so the downstream register only ever loads complete words.

## Interface
- DATA_W, 4: data bits per frame and width of dout. Legal range 2..16.
- PARITY_EN, 1: 1 = an even-parity bit follows the data bits; 0 = no parity bit, parity_err tied 0.
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- sin  in  1  serial data line, idle level 1.
- sin_valid  in  1  bit strobe; sin is sampled only on cycles with sin_valid=1.
- dout  out  DATA_W  assembled word, LSB = first data bit received.
- dout_valid  out  1  dout holds an unconsumed word.
- dout_ready  in  1  downstream accepts dout when dout_valid & dout_ready.
- parity_err  out  1  parity status of the word on dout; valid while dout_valid=1.
- frame_err  out  1  one-cycle pulse: stop bit sampled as 0.
- overrun  out  1  one-cycle pulse: completed word dropped because the buffer was full.
- busy  out  1  1 whenever FSM is not in IDLE.

## Operation
- FSM states: IDLE, DATA, PARITY, STOP, WAIT_HIGH. All transitions occur only on sin_valid=1 cycles. With sin_valid=0, the state, bit counter and shift register hold.
- IDLE: sin=0 → DATA, clear bit counter and running parity. sin=1 → stay.
- DATA: shift sin into shift register at bit position = counter (LSB first); XOR sin into running parity; counter++.
  - After bit DATA_W-1 is sampled: go to PARITY if PARITY_EN=1, else STOP.
- PARITY: capture perr = running_parity XOR sin, so even parity over data plus parity bit is required. → STOP.
- STOP: sin=1 → word complete, go to IDLE. sin=0 → frame_err pulse, word discarded, go to WAIT_HIGH.
- WAIT_HIGH: stay until sin=1 is sampled, then IDLE. This prevents a held-low line from being read as a new start bit.
- Word complete:
  - If the buffer is empty, or is being drained in the same cycle (dout_valid & dout_ready), load dout and parity_err and set dout_valid.
  - Otherwise, keep the old word, drop the new one and pulse overrun.
- Handshake: dout_valid & dout_ready with no simultaneous load → dout_valid clears next cycle. dout and parity_err hold their values while dout_valid=1.
- A parity error does not discard the word; it is delivered with parity_err=1.
- Reset values:
  - State IDLE, counter 0, shift register 0.
  - dout=0, dout_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
- Reset mid-frame aborts the frame; any partial word is lost. Reset also clears a pending buffered word.

## Timing
- All outputs are registered.
- Latency: dout_valid=1 on the cycle after the clock edge that samples a valid stop bit (sin_valid=1, sin=1 in STOP).
- frame_err and overrun are asserted for exactly the one cycle following the causing sample.
- busy rises the cycle after the start bit is sampled. It falls the cycle after the stop bit is sampled, or after sin=1 is sampled in WAIT_HIGH.
- Throughput: back-to-back frames are supported; a start bit may be sampled on the strobe immediately after a stop bit.
- Simultaneous stop-bit completion and consumption of the old word: the new word loads, dout_valid stays 1, no overrun.
- sin_valid may be asserted on every cycle or sparsely; behaviour is identical apart from elapsed cycles.

## Test plan
- Reset check: assert reset for 2 cycles mid-frame, then release with sin=1 → every output 0, FSM in IDLE, next well-formed frame decodes correctly.
- Basic frame, defaults, sin_valid every cycle: bits 0,1,0,1,1,1,1 (start, data 1,0,1,1, parity 1, stop) → dout=4'hD, parity_err=0, dout_valid rises one cycle after the stop sample. Drive dout_ready=1 → dout_valid clears next cycle.
- Parity error: same frame with parity bit 0 → dout=4'hD delivered with parity_err=1; frame_err=0.
- Framing error: frame with data 4'h3 and stop bit 0, then sin held 0 for 3 strobes, then 1, then a valid frame with data 4'h6 → one frame_err pulse, no word from the bad frame, no false start while sin stays low, next dout=4'h6.
- Overrun and drain collision: with dout_ready=0, receive 4'hA then 4'h5 → dout stays 4'hA and overrun pulses once. Repeat with dout_ready=1 on exactly the stop-sample cycle of 4'h5 → dout=4'h5, dout_valid stays 1, no overrun.
- Sparse strobes: sin_valid asserted every 3rd cycle with random idle-cycle sin values, frame with data 4'h9 → dout=4'h9; non-strobed cycles have no effect.

Source files
------------

// File: rtl/sipo_frame_deserializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sipo_frame_deserializer: strobe-qualified framed serial-to-parallel      |
// | receiver with even parity, one-deep valid/ready output buffer.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sipo_frame_deserializer #(
  parameter int DATA_W    = 4,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sin_i,
  input  logic              sin_valid_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              dout_valid_o,
  input  logic              dout_ready_i,
  output logic              parity_err_o,
  output logic              frame_err_o,
  output logic              overrun_o,
  output logic              busy_o
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DATA      = 3'd1,
    S_PARITY    = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_q, par_d;
  logic                perr_q, perr_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                parity_err_q, parity_err_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;
  logic                busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      perr_q       <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      perr_q       <= perr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    perr_d       = perr_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;

    if (dout_valid_q && dout_ready_i) dout_valid_d = 1'b0;

    if (sin_valid_i) begin
      unique case (state_q)
        S_IDLE: begin
          if (!sin_i) begin
            state_d = S_DATA;
            cnt_d   = '0;
            par_d   = 1'b0;
            perr_d  = 1'b0;
          end
        end
        S_DATA: begin
          shift_d[cnt_q] = sin_i;
          par_d          = par_q ^ sin_i;
          cnt_d          = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
        S_PARITY: begin
          perr_d  = par_q ^ sin_i;
          state_d = S_STOP;
        end
        S_STOP: begin
          if (sin_i) begin
            state_d = S_IDLE;
            // A drain in this same cycle frees the buffer for the new word.
            if (!dout_valid_q || dout_ready_i) begin
              dout_d       = shift_q;
              parity_err_d = (PARITY_EN != 0) ? perr_q : 1'b0;
              dout_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_HIGH;
          end
        end
        S_WAIT_HIGH: begin
          if (sin_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = dout_valid_q;
  assign parity_err_o = parity_err_q;
  assign frame_err_o  = frame_err_q;
  assign overrun_o    = overrun_q;
  assign busy_o       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sipo_frame_deserializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sipo_frame_deserializer: directed and randomized frames checked       |
// | against a frame-level behavioural model. Rev 1.0                         |
// +--------------------------------------------------------------------------+
module tb_sipo_frame_deserializer;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sin = 1'b1;
  logic          sin_valid = 1'b0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic          parity_err;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Frame-level model of what the outputs should show.
  logic [DW-1:0] exp_dout  = '0;
  logic          exp_valid = 1'b0;
  logic          exp_perr  = 1'b0;
  logic          exp_ferr  = 1'b0;
  logic          exp_ovr   = 1'b0;
  logic          exp_busy  = 1'b0;

  sipo_frame_deserializer #(.DATA_W(DW), .PARITY_EN(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .sin_i        (sin),
    .sin_valid_i  (sin_valid),
    .dout_o       (dout),
    .dout_valid_o (dout_valid),
    .dout_ready_i (dout_ready),
    .parity_err_o (parity_err),
    .frame_err_o  (frame_err),
    .overrun_o    (overrun),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".dout"},       32'(dout),       32'(exp_dout));
    check({tag, ".dout_valid"}, 32'(dout_valid), 32'(exp_valid));
    check({tag, ".parity_err"}, 32'(parity_err), 32'(exp_perr));
    check({tag, ".frame_err"},  32'(frame_err),  32'(exp_ferr));
    check({tag, ".overrun"},    32'(overrun),    32'(exp_ovr));
    check({tag, ".busy"},       32'(busy),       32'(exp_busy));
  endtask

  task automatic idle_cycles(input int gap);
    for (int g = 0; g < gap; g++) begin
      sin       = 1'($urandom);
      sin_valid = 1'b0;
      tick();
    end
  endtask

  task automatic send_bit(input logic b, input int gap);
    idle_cycles(gap);
    sin       = b;
    sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    sin        = 1'b1;
    sin_valid  = 1'b0;
    dout_ready = 1'b0;
    tick();
    tick();
    reset      = 1'b0;
    exp_dout   = '0;
    exp_valid  = 1'b0;
    exp_perr   = 1'b0;
    exp_ferr   = 1'b0;
    exp_ovr    = 1'b0;
    exp_busy   = 1'b0;
    check_outputs("reset");
  endtask

  // One frame: start, data LSB first, parity (optionally wrong), stop.
  task automatic frame(input logic [DW-1:0] data, input bit bad_par, input bit stop,
                       input bit rdy_at_stop, input int gap);
    logic consumed;
    send_bit(1'b0, gap);
    exp_busy = 1'b1;
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
    check_outputs("start");
    for (int i = 0; i < DW; i++) send_bit(data[i], gap);
    send_bit((^data) ^ bad_par, gap);
    idle_cycles(gap);
    dout_ready = rdy_at_stop;
    sin        = stop;
    sin_valid  = 1'b1;
    tick();
    sin_valid  = 1'b0;
    dout_ready = 1'b0;
    consumed   = rdy_at_stop && exp_valid;
    if (stop) begin
      exp_busy = 1'b0;
      if (!exp_valid || consumed) begin
        exp_dout  = data;
        exp_perr  = bad_par;
        exp_valid = 1'b1;
      end else begin
        exp_ovr = 1'b1;
      end
    end else begin
      exp_busy = 1'b1;
      exp_ferr = 1'b1;
      if (consumed) exp_valid = 1'b0;
    end
    check_outputs("stop");
    idle_cycles(1);
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
    check_outputs("post");
  endtask

  task automatic wait_high(input int n_low);
    for (int i = 0; i < n_low; i++) begin
      send_bit(1'b0, 0);
      check_outputs("wait_low");
    end
    send_bit(1'b1, 0);
    exp_busy = 1'b0;
    check_outputs("wait_high");
  endtask

  task automatic drain();
    dout_ready = 1'b1;
    sin_valid  = 1'b0;
    tick();
    dout_ready = 1'b0;
    exp_valid  = 1'b0;
    check_outputs("drain");
  endtask

  initial begin
    do_reset();

    // Basic frame 0,1,0,1,1,1,1 and parity error variant.
    frame(4'hD, 1'b0, 1'b1, 1'b0, 0);
    drain();
    frame(4'hD, 1'b1, 1'b1, 1'b0, 0);
    drain();

    // Framing error, line held low, recovery.
    frame(4'h3, 1'b0, 1'b0, 1'b0, 0);
    wait_high(3);
    frame(4'h6, 1'b0, 1'b1, 1'b0, 0);
    drain();

    // Overrun, then drain collision on the stop sample.
    frame(4'hA, 1'b0, 1'b1, 1'b0, 0);
    frame(4'h5, 1'b0, 1'b1, 1'b0, 0);
    drain();
    frame(4'hA, 1'b0, 1'b1, 1'b0, 0);
    frame(4'h5, 1'b0, 1'b1, 1'b1, 0);
    drain();

    // Sparse strobes: every 3rd cycle.
    frame(4'h9, 1'b0, 1'b1, 1'b0, 2);
    drain();

    // Reset mid-frame with a buffered word pending.
    frame(4'hA, 1'b0, 1'b1, 1'b0, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    do_reset();
    frame(4'h6, 1'b0, 1'b1, 1'b0, 0);
    drain();

    // Randomized frames.
    for (int k = 0; k < 24; k++) begin
      logic [DW-1:0] d;
      bit            st;
      d  = DW'($urandom_range(0, (1 << DW) - 1));
      st = ($urandom_range(0, 5) != 0);
      frame(d, 1'($urandom), st, 1'($urandom), int'($urandom_range(0, 3)));
      if (!st) wait_high(int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
